cp0_reg: RTL
============

CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 Parameter PRID_VAL, 32'h004C0102, value returned for PRId (reg 15).
REQ-002 Parameter CONFIG_VAL, 32'h00008000, value returned for Config (reg 16).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we_i  in  1  MTC0 write enable.
REQ-007 waddr_i  in  5  MTC0 destination register number.
REQ-008 wdata_i  in  32  MTC0 write data.
REQ-009 raddr_i  in  5  MFC0 source register number.
REQ-010 int_i  in  6  external hardware interrupt lines.
REQ-011 excepttype_i  in  32  exception code from the exception stage (0 = none).
REQ-012 pc_i  in  32  address of the instruction committing this cycle.
REQ-013 is_in_delayslot_i  in  1  that instruction sits in a branch delay slot.
REQ-014 bad_addr_i  in  32  faulting address for address-error exceptions.
REQ-015 rdata_o  out  32  MFC0 read data.
REQ-016 count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  live register values.
REQ-017 timer_int_o  out  1  timer interrupt pending.

Function
REQ-018 Register map SHALL be: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
REQ-019 rdata_o SHALL be combinational from raddr_i and current register state; no write bypass; unmapped addresses return 0.
REQ-020 Count SHALL increment by 1 on every second clk, using a 1-bit phase toggle; it wraps 32'hFFFFFFFF -> 0.
REQ-021 An MTC0 to Count SHALL load wdata_i in place of that cycle's increment; the phase toggle continues unaffected.
REQ-022 timer_int_o SHALL be set (registered) when Compare != 0 and Count == Compare; it holds until an MTC0 to Compare or reset.
REQ-023 An MTC0 to Compare SHALL load wdata_i and clear timer_int_o in the same edge; a match on that edge is ignored.
REQ-024 Cause[15:10] SHALL be loaded from int_i every cycle; Cause[30] (TI) SHALL mirror timer_int_o, one cycle later.
REQ-025 MTC0 writable bits: Status[15:8], Status[1], Status[0]; Cause[9:8]; EPC[31:0]; all other bits and registers are read-only, and writes to them are dropped.
REQ-026 When excepttype_i is one of 1, 4, 5, 8, 9, A, C:
  - if Status.EXL == 0, EPC <= pc_i - 4 and Cause.BD <= 1 when is_in_delayslot_i, else EPC <= pc_i and Cause.BD <= 0;
  - if Status.EXL == 1, EPC and BD are unchanged;
  - Status.EXL <= 1 and Cause[6:2] <= code (1 maps to 0, others map to their own value).
REQ-027 For codes 4 and 5, BadVAddr SHALL additionally load bad_addr_i.
REQ-028 For code E (ERET), Status.EXL SHALL be cleared; no other field changes.
REQ-029 Any other nonzero excepttype_i value SHALL cause no register change.
REQ-030 In a cycle with a recognised nonzero excepttype_i, the MTC0 write SHALL be dropped entirely; the Count increment and int_i sampling still occur.
REQ-031 Latency: every update is visible on outputs in the cycle after the sampling edge.

Reset
REQ-032 On rst at a clk edge, the following SHALL be loaded, overriding all other activity that cycle:
  - Count = 0, Compare = 0, Cause = 0, EPC = 0, BadVAddr = 0;
  - Status = 32'h00400000;
  - timer_int_o = 0, phase = 0.
REQ-033 rst asserted mid-exception or mid-write SHALL discard the pending update.

Verification
REQ-034 Reset, then run 10 cycles idle -> count_o = 5, status_o = 32'h00400000, all other outputs 0.
REQ-035 MTC0 Compare = 3 with Count = 0 -> timer_int_o rises 1 cycle after Count reaches 3, and cause_o[30] follows 1 cycle later; a later MTC0 Compare = 0 -> timer_int_o = 0 next cycle.
REQ-036 excepttype_i = 4, pc_i = 32'h80001000, is_in_delayslot_i = 1, bad_addr_i = 32'h1235 -> epc_o = 32'h80000FFC, cause_o[31] = 1, cause_o[6:2] = 4, badvaddr_o = 32'h1235, status_o[1] = 1.
REQ-037 Second exception (code 8, pc_i = 32'h80002000) while EXL = 1 -> EPC unchanged at 32'h80000FFC, ExcCode = 8; then excepttype_i = E -> status_o[1] = 0.
REQ-038 Same cycle: we_i writing EPC = 32'hDEAD and excepttype_i = C -> EPC = pc_i, not 32'hDEAD; we_i writing Status = 32'hFFFFFFFF without exception -> status_o = 32'h0040FF03.
REQ-039 Count preloaded to 32'hFFFFFFFF -> wraps to 0 after 2 cycles; raddr_i = 9 returns the same value as count_o.

Source files
------------

// File: rtl/cp0_reg_if.sv
// MIPS CP0 register file port bundle: MTC0/MFC0 access, exception commit info
// and the live register taps.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] rdata_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i,
           is_in_delayslot_i, bad_addr_i,
    input  rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
           timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i,
           is_in_delayslot_i, bad_addr_i,
    output rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
           timer_int_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 subset: Count/Compare timer, Status/Cause/EPC/BadVAddr with
// exception entry/ERET handling, MTC0 writes and combinational MFC0 reads.
module cp0_reg #(
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input logic      clk,
  input logic      rst,
  cp0_reg_if.slave bus
);
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h00400000;

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] status_reg;
  logic [31:0] cause_reg;
  logic [31:0] epc_reg;
  logic [31:0] badvaddr_reg;
  logic        timer_int_reg;
  logic        phase_reg;

  logic        exc_take;
  logic        exc_addr;
  logic        exc_eret;
  logic        wr_en;
  logic [4:0]  exc_code;
  logic [31:0] rdata_next;

  always_comb begin
    exc_take = 1'b0;
    exc_addr = 1'b0;
    exc_eret = 1'b0;
    case (bus.excepttype_i)
      32'h1, 32'h8, 32'h9, 32'hA, 32'hC: exc_take = 1'b1;
      32'h4, 32'h5: begin
        exc_take = 1'b1;
        exc_addr = 1'b1;
      end
      32'hE:   exc_eret = 1'b1;
      default: ;
    endcase
  end

  // Interrupt (code 1) is reported as ExcCode 0.
  assign exc_code = (bus.excepttype_i == 32'h1) ? 5'd0 : bus.excepttype_i[4:0];
  assign wr_en    = bus.we_i && !exc_take && !exc_eret;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      compare_reg   <= '0;
      status_reg    <= STATUS_RESET;
      cause_reg     <= '0;
      epc_reg       <= '0;
      badvaddr_reg  <= '0;
      timer_int_reg <= 1'b0;
      phase_reg     <= 1'b0;
    end else begin
      phase_reg <= ~phase_reg;

      if (wr_en && bus.waddr_i == ADDR_COUNT)
        count_reg <= bus.wdata_i;
      else if (phase_reg)
        count_reg <= count_reg + 32'd1;

      // A Compare write wins over a match on the same edge.
      if (wr_en && bus.waddr_i == ADDR_COMPARE) begin
        compare_reg   <= bus.wdata_i;
        timer_int_reg <= 1'b0;
      end else if (compare_reg != 32'd0 && count_reg == compare_reg) begin
        timer_int_reg <= 1'b1;
      end

      cause_reg[15:10] <= bus.int_i;
      cause_reg[30]    <= timer_int_reg;

      if (wr_en) begin
        case (bus.waddr_i)
          ADDR_STATUS: begin
            status_reg[15:8] <= bus.wdata_i[15:8];
            status_reg[1:0]  <= bus.wdata_i[1:0];
          end
          ADDR_CAUSE: cause_reg[9:8] <= bus.wdata_i[9:8];
          ADDR_EPC:   epc_reg        <= bus.wdata_i;
          default: ;
        endcase
      end

      // Nested exceptions (EXL already set) keep the original EPC and BD.
      if (exc_take) begin
        if (!status_reg[1]) begin
          epc_reg       <= bus.is_in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          cause_reg[31] <= bus.is_in_delayslot_i;
        end
        status_reg[1]  <= 1'b1;
        cause_reg[6:2] <= exc_code;
        if (exc_addr)
          badvaddr_reg <= bus.bad_addr_i;
      end else if (exc_eret) begin
        status_reg[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    case (bus.raddr_i)
      ADDR_BADVADDR: rdata_next = badvaddr_reg;
      ADDR_COUNT:    rdata_next = count_reg;
      ADDR_COMPARE:  rdata_next = compare_reg;
      ADDR_STATUS:   rdata_next = status_reg;
      ADDR_CAUSE:    rdata_next = cause_reg;
      ADDR_EPC:      rdata_next = epc_reg;
      ADDR_PRID:     rdata_next = PRID_VAL;
      ADDR_CONFIG:   rdata_next = CONFIG_VAL;
      default:       rdata_next = '0;
    endcase
  end

  assign bus.rdata_o     = rdata_next;
  assign bus.count_o     = count_reg;
  assign bus.compare_o   = compare_reg;
  assign bus.status_o    = status_reg;
  assign bus.cause_o     = cause_reg;
  assign bus.epc_o       = epc_reg;
  assign bus.badvaddr_o  = badvaddr_reg;
  assign bus.timer_int_o = timer_int_reg;
endmodule
